// File: rtl/spi_port_arb_if.sv
// Signal bundle shared by the two SPI masters, the port arbiter and the SPI pin port.
// The arbiter connects through the slave modport; the master modport is the environment side.
interface spi_port_arb_if;
  logic       m0_req;
  logic       m1_req;
  logic       m0_gnt;
  logic       m1_gnt;
  logic       m0_abort;
  logic       m1_abort;
  logic       m0_sck;
  logic       m0_cs;
  logic       m1_sck;
  logic       m1_cs;
  logic [3:0] m0_dq_o;
  logic [3:0] m0_dq_oe;
  logic [3:0] m1_dq_o;
  logic [3:0] m1_dq_oe;
  logic [3:0] m0_dq_i;
  logic [3:0] m1_dq_i;
  logic       port_sck;
  logic       port_cs;
  logic [3:0] port_dq_o;
  logic [3:0] port_dq_oe;
  logic [3:0] port_dq_i;
  logic       busy;

  modport slave (
    input  m0_req, m1_req, m0_sck, m0_cs, m1_sck, m1_cs,
           m0_dq_o, m0_dq_oe, m1_dq_o, m1_dq_oe, port_dq_i,
    output m0_gnt, m1_gnt, m0_abort, m1_abort, m0_dq_i, m1_dq_i,
           port_sck, port_cs, port_dq_o, port_dq_oe, busy
  );

  modport master (
    output m0_req, m1_req, m0_sck, m0_cs, m1_sck, m1_cs,
           m0_dq_o, m0_dq_oe, m1_dq_o, m1_dq_oe, port_dq_i,
    input  m0_gnt, m1_gnt, m0_abort, m1_abort, m0_dq_i, m1_dq_i,
           port_sck, port_cs, port_dq_o, port_dq_oe, busy
  );
endinterface

// File: rtl/spi_port_arb.sv
// Two-master quad-SPI pin port arbiter with round-robin contention and a forced CS-high gap.
// Define SPI_ARB_TIMEOUT_EN to build in the MAX_HOLD grant timeout and the abort pulses.
module spi_port_arb #(
  parameter int unsigned CS_GAP   = 2,
  parameter int unsigned MAX_HOLD = 1024,
  parameter logic        SCK_IDLE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_port_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_e;

  localparam logic [7:0] GapLoad = 8'(CS_GAP - 1);

  state_e     state_q;
  logic       rr_q;
  logic [7:0] gap_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       timeout0;
  logic       timeout1;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] HoldLast = 16'(MAX_HOLD - 1);

  logic [15:0] hold_q;
  logic        abort0_q;
  logic        abort1_q;

  // The hold budget is spent only on cycles where the other master is waiting.
  assign timeout0 = bus.m1_req && (hold_q == HoldLast);
  assign timeout1 = bus.m0_req && (hold_q == HoldLast);
  assign bus.m0_abort = abort0_q;
  assign bus.m1_abort = abort1_q;
`else
  assign timeout0 = 1'b0;
  assign timeout1 = 1'b0;
  assign bus.m0_abort = 1'b0;
  assign bus.m1_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gap_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_q   <= '0;
      abort0_q <= 1'b0;
      abort1_q <= 1'b0;
`endif
    end else begin
`ifdef SPI_ARB_TIMEOUT_EN
      abort0_q <= 1'b0;
      abort1_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.m0_req && (!bus.m1_req || !rr_q)) begin
            state_q <= OWN0;
            gnt0_q  <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end else if (bus.m1_req) begin
            state_q <= OWN1;
            gnt1_q  <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end

        // A voluntary release wins over a timeout landing in the same cycle.
        OWN0: begin
          if (!bus.m0_req || timeout0) begin
            gnt0_q <= 1'b0;
            rr_q   <= 1'b1;
            if (CS_GAP > 0) begin
              state_q <= GAP;
              gap_q   <= GapLoad;
            end else begin
              state_q <= IDLE;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            abort0_q <= bus.m0_req;
          end else if (bus.m1_req) begin
            hold_q <= hold_q + 16'd1;
`endif
          end
        end

        OWN1: begin
          if (!bus.m1_req || timeout1) begin
            gnt1_q <= 1'b0;
            rr_q   <= 1'b0;
            if (CS_GAP > 0) begin
              state_q <= GAP;
              gap_q   <= GapLoad;
            end else begin
              state_q <= IDLE;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            abort1_q <= bus.m1_req;
          end else if (bus.m0_req) begin
            hold_q <= hold_q + 16'd1;
`endif
          end
        end

        GAP: begin
          if (gap_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
      endcase
    end
  end

  // Decoded from the registered state alone so reset parks the pins without a clock edge.
  always_comb begin
    bus.port_sck   = SCK_IDLE;
    bus.port_cs    = 1'b1;
    bus.port_dq_o  = 4'h0;
    bus.port_dq_oe = 4'h0;
    case (state_q)
      OWN0: begin
        bus.port_sck   = bus.m0_sck;
        bus.port_cs    = bus.m0_cs;
        bus.port_dq_o  = bus.m0_dq_o;
        bus.port_dq_oe = bus.m0_dq_oe;
      end
      OWN1: begin
        bus.port_sck   = bus.m1_sck;
        bus.port_cs    = bus.m1_cs;
        bus.port_dq_o  = bus.m1_dq_o;
        bus.port_dq_oe = bus.m1_dq_oe;
      end
      default: ;
    endcase
  end

  assign bus.m0_gnt  = gnt0_q;
  assign bus.m1_gnt  = gnt1_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.m0_dq_i = bus.port_dq_i;
  assign bus.m1_dq_i = bus.port_dq_i;

endmodule

// File: tb/tb_spi_port_arb.sv
// Scoreboard bench: two arbiters (CS_GAP=2 and CS_GAP=0) share randomized stimulus and are
// compared every cycle against a cycle-arithmetic model of ownership, gap timing and round-robin.
`timescale 1ns/1ps
module tb_spi_port_arb;

  localparam int MaxHold = 8;
  localparam int GapA    = 2;
  localparam int GapB    = 0;

  typedef struct {
    logic       gnt0;
    logic       gnt1;
    logic       abort0;
    logic       abort1;
    logic       busy;
    logic       sck;
    logic       cs;
    logic [3:0] dqO;
    logic [3:0] dqOe;
    logic [3:0] dqI0;
    logic [3:0] dqI1;
  } expT;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_port_arb_if ifA();
  spi_port_arb_if ifB();

  spi_port_arb #(.CS_GAP(GapA), .MAX_HOLD(MaxHold), .SCK_IDLE(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA)
  );
  spi_port_arb #(.CS_GAP(GapB), .MAX_HOLD(MaxHold), .SCK_IDLE(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB)
  );

  int checkCount = 0;
  int passCount  = 0;

  expT expQ[2][$];

  logic       reqV[2];
  logic       sckV[2];
  logic       csV[2];
  logic [3:0] dqOV[2];
  logic [3:0] dqOeV[2];
  logic [3:0] dqIV;

  int   gapOf[2]   = '{GapA, GapB};
  logic sckIdle[2] = '{1'b0, 1'b1};

  // Model: who owns the port, first cycle a new grant may appear, and whom contention favours.
  int   owner[2];
  int   freeAt[2];
  int   favour[2];
  int   contended[2];
  logic lastAbort[2];
  int   cyc = 0;

  task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv)
      $display("[TB] FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", d, name, act, expv, cyc);
    else
      passCount++;
  endtask

  function automatic expT snapA();
    expT s;
    s.gnt0 = ifA.m0_gnt;     s.gnt1 = ifA.m1_gnt;
    s.abort0 = ifA.m0_abort; s.abort1 = ifA.m1_abort;
    s.busy = ifA.busy;       s.sck = ifA.port_sck;    s.cs = ifA.port_cs;
    s.dqO = ifA.port_dq_o;   s.dqOe = ifA.port_dq_oe;
    s.dqI0 = ifA.m0_dq_i;    s.dqI1 = ifA.m1_dq_i;
    return s;
  endfunction

  function automatic expT snapB();
    expT s;
    s.gnt0 = ifB.m0_gnt;     s.gnt1 = ifB.m1_gnt;
    s.abort0 = ifB.m0_abort; s.abort1 = ifB.m1_abort;
    s.busy = ifB.busy;       s.sck = ifB.port_sck;    s.cs = ifB.port_cs;
    s.dqO = ifB.port_dq_o;   s.dqOe = ifB.port_dq_oe;
    s.dqI0 = ifB.m0_dq_i;    s.dqI1 = ifB.m1_dq_i;
    return s;
  endfunction

  task automatic compareAll(input int d, input expT act, input expT e);
    checkOutput("m0_gnt", d, 32'(act.gnt0), 32'(e.gnt0));
    checkOutput("m1_gnt", d, 32'(act.gnt1), 32'(e.gnt1));
    checkOutput("m0_abort", d, 32'(act.abort0), 32'(e.abort0));
    checkOutput("m1_abort", d, 32'(act.abort1), 32'(e.abort1));
    checkOutput("busy", d, 32'(act.busy), 32'(e.busy));
    checkOutput("port_sck", d, 32'(act.sck), 32'(e.sck));
    checkOutput("port_cs", d, 32'(act.cs), 32'(e.cs));
    checkOutput("port_dq_o", d, 32'(act.dqO), 32'(e.dqO));
    checkOutput("port_dq_oe", d, 32'(act.dqOe), 32'(e.dqOe));
    checkOutput("m0_dq_i", d, 32'(act.dqI0), 32'(e.dqI0));
    checkOutput("m1_dq_i", d, 32'(act.dqI1), 32'(e.dqI1));
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; freeAt[d] = 0; favour[d] = 0; contended[d] = 0;
      lastAbort[d] = 1'b0;
      expQ[d].delete();
    end
  endtask

  task automatic driveInputs();
    ifA.m0_req = reqV[0];  ifB.m0_req = reqV[0];
    ifA.m1_req = reqV[1];  ifB.m1_req = reqV[1];
    ifA.m0_sck = sckV[0];  ifB.m0_sck = sckV[0];
    ifA.m1_sck = sckV[1];  ifB.m1_sck = sckV[1];
    ifA.m0_cs = csV[0];    ifB.m0_cs = csV[0];
    ifA.m1_cs = csV[1];    ifB.m1_cs = csV[1];
    ifA.m0_dq_o = dqOV[0]; ifB.m0_dq_o = dqOV[0];
    ifA.m1_dq_o = dqOV[1]; ifB.m1_dq_o = dqOV[1];
    ifA.m0_dq_oe = dqOeV[0]; ifB.m0_dq_oe = dqOeV[0];
    ifA.m1_dq_oe = dqOeV[1]; ifB.m1_dq_oe = dqOeV[1];
    ifA.port_dq_i = dqIV;  ifB.port_dq_i = dqIV;
  endtask

  task automatic driveIdle();
    for (int x = 0; x < 2; x++) begin
      reqV[x] = 1'b0; sckV[x] = 1'b0; csV[x] = 1'b1; dqOV[x] = 4'h0; dqOeV[x] = 4'h0;
    end
    dqIV = 4'h0;
    driveInputs();
  endtask

  task automatic releasePort(input int d, input int o);
    owner[d]  = -1;
    favour[d] = 1 - o;
    freeAt[d] = cyc + gapOf[d] + 2;
  endtask

  // Advances the model over the clock edge that closes the current cycle.
  task automatic modelStep(input int d, output expT e);
    logic ab[2];
    ab = '{1'b0, 1'b0};
    if (owner[d] >= 0) begin
      int o;
      o = owner[d];
      if (!reqV[o]) begin
        releasePort(d, o);
      end else begin
`ifdef SPI_ARB_TIMEOUT_EN
        if (reqV[1 - o]) contended[d]++;
        if (contended[d] == MaxHold) begin
          releasePort(d, o);
          ab[o] = 1'b1;
        end
`endif
      end
    end else if (cyc + 1 >= freeAt[d]) begin
      if (reqV[0] && reqV[1]) owner[d] = favour[d];
      else if (reqV[0])       owner[d] = 0;
      else if (reqV[1])       owner[d] = 1;
      contended[d] = 0;
    end
    e.gnt0 = (owner[d] == 0);
    e.gnt1 = (owner[d] == 1);
    e.abort0 = ab[0];
    e.abort1 = ab[1];
    e.busy = (owner[d] >= 0) || (cyc + 1 <= freeAt[d] - 2);
    if (owner[d] >= 0) begin
      e.sck = sckV[owner[d]]; e.cs = csV[owner[d]];
      e.dqO = dqOV[owner[d]]; e.dqOe = dqOeV[owner[d]];
    end else begin
      e.sck = sckIdle[d]; e.cs = 1'b1; e.dqO = 4'h0; e.dqOe = 4'h0;
    end
    e.dqI0 = dqIV;
    e.dqI1 = dqIV;
    if (d == 0) lastAbort = ab;
  endtask

  task automatic applyStimulus(input logic r0, input logic r1);
    expT e;
    @(negedge clk);
    reqV[0] = r0;
    reqV[1] = r1;
    for (int x = 0; x < 2; x++) begin
      sckV[x]  = 1'($urandom);
      csV[x]   = 1'($urandom);
      dqOV[x]  = 4'($urandom);
      dqOeV[x] = 4'($urandom);
    end
    dqIV = 4'($urandom);
    driveInputs();
    for (int d = 0; d < 2; d++) begin
      modelStep(d, e);
      expQ[d].push_back(e);
    end
    cyc++;
  endtask

  task automatic checkResetState(input int d, input expT act);
    checkOutput("rst m0_gnt", d, 32'(act.gnt0), 32'd0);
    checkOutput("rst m1_gnt", d, 32'(act.gnt1), 32'd0);
    checkOutput("rst m0_abort", d, 32'(act.abort0), 32'd0);
    checkOutput("rst m1_abort", d, 32'(act.abort1), 32'd0);
    checkOutput("rst busy", d, 32'(act.busy), 32'd0);
    checkOutput("rst port_cs", d, 32'(act.cs), 32'd1);
    checkOutput("rst port_sck", d, 32'(act.sck), 32'(sckIdle[d]));
    checkOutput("rst port_dq_oe", d, 32'(act.dqOe), 32'd0);
    checkOutput("rst port_dq_o", d, 32'(act.dqO), 32'd0);
  endtask

  // Monitor: every cycle each arbiter presents a response, compared to the oldest expectation.
  always @(posedge clk) begin
    expT e;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (expQ[d].size() > 0) begin
        e = expQ[d].pop_front();
        compareAll(d, (d == 0) ? snapA() : snapB(), e);
      end
    end
  end

  int segR0[13]  = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0};
  int segR1[13]  = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0};
  int segLen[13] = '{4, 12, 5, 12, 12, 6, 8, 5, 10, 5, 3, 20, 6};

  initial begin
    logic nr[2];
    rst_n = 1'b0;
    driveIdle();
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkResetState(0, snapA());
    checkResetState(1, snapB());
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 13; s++)
      for (int k = 0; k < segLen[s]; k++)
        applyStimulus(segR0[s] != 0, segR1[s] != 0);

    for (int n = 0; n < 2000; n++) begin
      for (int x = 0; x < 2; x++) begin
        if (!reqV[x])               nr[x] = ($urandom_range(3) == 0);
        else if (lastAbort[x])      nr[x] = 1'b0;
        else if (owner[0] == x)     nr[x] = ($urandom_range(9) != 0);
        else                        nr[x] = ($urandom_range(15) != 0);
      end
      applyStimulus(nr[0], nr[1]);
    end

    // Park both arbiters in OWN1, then pull reset between clock edges.
    repeat (10) applyStimulus(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async port_cs", 0, 32'(ifA.port_cs), 32'd1);
    checkOutput("async m1_gnt", 0, 32'(ifA.m1_gnt), 32'd0);
    checkOutput("async port_cs", 1, 32'(ifB.port_cs), 32'd1);
    checkOutput("async m1_gnt", 1, 32'(ifB.m1_gnt), 32'd0);
    driveIdle();
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0);

    @(posedge clk);
    #3;
    checkOutput("queue drained", 0, 32'(expQ[0].size() + expQ[1].size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
